// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared types for the maze depth-first search controller
package maze_pkg;

  localparam int COORD_W = 4;

  typedef enum logic [1:0] {
    DIR_PX,
    DIR_PY,
    DIR_NX,
    DIR_NY
  } dir_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_CHECK,
    ST_EVAL,
    ST_MOVE,
    ST_BACK,
    ST_POPW,
    ST_DONE,
    ST_NOPATH
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

endpackage

// File: rtl/maze_nbr_calc.sv
// rtl/maze_nbr_calc.sv - neighbor coordinate of cur in direction dir, flags grid exit
import maze_pkg::*;

module maze_nbr_calc (
  input  coord_t cur,
  input  dir_e   dir,
  output coord_t n,
  output logic   out_of_grid
);

  always_comb begin
    n           = cur;
    out_of_grid = 1'b0;
    case (dir)
      DIR_PX: begin
        n.x         = cur.x + COORD_W'(1);
        out_of_grid = &cur.x;
      end
      DIR_PY: begin
        n.y         = cur.y + COORD_W'(1);
        out_of_grid = &cur.y;
      end
      DIR_NX: begin
        n.x         = cur.x - COORD_W'(1);
        out_of_grid = (cur.x == '0);
      end
      default: begin
        n.y         = cur.y - COORD_W'(1);
        out_of_grid = (cur.y == '0);
      end
    endcase
  end

endmodule

// File: rtl/maze_dfs_ctrl.sv
// rtl/maze_dfs_ctrl.sv - depth-first maze walker driving an external coordinate stack
import maze_pkg::*;

module maze_dfs_ctrl #(
  parameter int MAX_DEPTH = 64,
  parameter int GOAL_X    = 15,
  parameter int GOAL_Y    = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [2*COORD_W-1:0] mem_addr,
  output logic                 mem_rd,
  input  logic                 mem_rdata,
  output logic                 mem_wr,
  output logic                 stk_push,
  output logic                 stk_pop,
  output logic [COORD_W-1:0]   stk_x,
  output logic [COORD_W-1:0]   stk_y,
  input  logic [COORD_W-1:0]   stk_x_out,
  input  logic [COORD_W-1:0]   stk_y_out,
  input  logic                 stk_fail,
  output logic [COORD_W-1:0]   cur_x,
  output logic [COORD_W-1:0]   cur_y,
  output logic                 busy,
  output logic                 done,
  output logic                 no_path
);

  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam logic [DW-1:0]      MAX_D = DW'(MAX_DEPTH);
  localparam logic [COORD_W-1:0] GX    = COORD_W'(GOAL_X);
  localparam logic [COORD_W-1:0] GY    = COORD_W'(GOAL_Y);

  state_e         state, state_n;
  coord_t         cur, cur_n, n;
  dir_e           dir, dir_n;
  logic [DW-1:0]  depth, depth_n;
  logic           oog;

  maze_nbr_calc u_nbr (
    .cur         (cur),
    .dir         (dir),
    .n           (n),
    .out_of_grid (oog)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cur   <= '0;
      dir   <= DIR_PX;
      depth <= '0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      dir   <= dir_n;
      depth <= depth_n;
    end
  end

  always_comb begin
    state_n  = state;
    cur_n    = cur;
    dir_n    = dir;
    depth_n  = depth;
    mem_addr = '0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_x    = '0;
    stk_y    = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_INIT;
          cur_n   = '0;
          dir_n   = DIR_PX;
          depth_n = '0;
        end
      end
      ST_INIT: begin
        mem_wr  = 1'b1;
        state_n = ST_CHECK;
      end
      ST_CHECK: begin
        // Off-grid neighbors are rejected without spending a memory read
        if (oog) begin
          if (dir == DIR_NY) state_n = ST_BACK;
          else               dir_n   = dir_e'(dir + 2'd1);
        end else begin
          mem_rd   = 1'b1;
          mem_addr = n;
          state_n  = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (!mem_rdata)          state_n = ST_MOVE;
        else if (dir == DIR_NY)  state_n = ST_BACK;
        else begin
          dir_n   = dir_e'(dir + 2'd1);
          state_n = ST_CHECK;
        end
      end
      ST_MOVE: begin
        if (depth == MAX_D) begin
          state_n = ST_NOPATH;
        end else begin
          stk_push = 1'b1;
          stk_x    = cur.x;
          stk_y    = cur.y;
          mem_wr   = 1'b1;
          mem_addr = n;
          cur_n    = n;
          depth_n  = depth + DW'(1);
          dir_n    = DIR_PX;
          state_n  = (n.x == GX && n.y == GY) ? ST_DONE : ST_CHECK;
        end
      end
      ST_BACK: begin
        stk_pop = 1'b1;
        state_n = ST_POPW;
      end
      ST_POPW: begin
        if (stk_fail) begin
          state_n = ST_NOPATH;
        end else begin
          cur_n.x = stk_x_out;
          cur_n.y = stk_y_out;
          depth_n = depth - DW'(1);
          dir_n   = DIR_PX;
          state_n = ST_CHECK;
        end
      end
      ST_DONE, ST_NOPATH: begin
        if (start) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign cur_x   = cur.x;
  assign cur_y   = cur.y;
  assign done    = (state == ST_DONE);
  assign no_path = (state == ST_NOPATH);
  assign busy    = !(state == ST_IDLE || state == ST_DONE || state == ST_NOPATH);

endmodule

// File: tb/tb_maze_dfs_ctrl.sv
// tb/tb_maze_dfs_ctrl.sv - directed self-checking bench for maze_dfs_ctrl
module tb_maze_dfs_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic sel = 1'b0;

  logic [7:0] a_addr, b_addr;
  logic       a_rd, a_wr, a_push, a_pop, b_rd, b_wr, b_push, b_pop;
  logic [3:0] a_sx, a_sy, a_cx, a_cy, b_sx, b_sy, b_cx, b_cy;
  logic       a_busy, a_done, a_np, b_busy, b_done, b_np;

  logic       mem_rdata;
  logic [3:0] s_x, s_y;
  logic       s_fail;

  logic [255:0] wall = '0;
  logic [255:0] visited;
  logic [7:0]   stk_mem  [0:127];
  logic [7:0]   push_log [0:127];
  int           sp, push_cnt, pop_cnt;
  int           n_checks = 0, n_fail = 0;
  int           cyc;

  always #5 clk = ~clk;

  maze_dfs_ctrl dut (
    .clk(clk), .rst(rst), .start(start_a),
    .mem_addr(a_addr), .mem_rd(a_rd), .mem_rdata(mem_rdata), .mem_wr(a_wr),
    .stk_push(a_push), .stk_pop(a_pop), .stk_x(a_sx), .stk_y(a_sy),
    .stk_x_out(s_x), .stk_y_out(s_y), .stk_fail(s_fail),
    .cur_x(a_cx), .cur_y(a_cy), .busy(a_busy), .done(a_done), .no_path(a_np)
  );

  maze_dfs_ctrl #(.MAX_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start_b),
    .mem_addr(b_addr), .mem_rd(b_rd), .mem_rdata(mem_rdata), .mem_wr(b_wr),
    .stk_push(b_push), .stk_pop(b_pop), .stk_x(b_sx), .stk_y(b_sy),
    .stk_x_out(s_x), .stk_y_out(s_y), .stk_fail(s_fail),
    .cur_x(b_cx), .cur_y(b_cy), .busy(b_busy), .done(b_done), .no_path(b_np)
  );

  wire [7:0] m_addr = sel ? b_addr : a_addr;
  wire       m_rd   = sel ? b_rd   : a_rd;
  wire       m_wr   = sel ? b_wr   : a_wr;
  wire       m_push = sel ? b_push : a_push;
  wire       m_pop  = sel ? b_pop  : a_pop;
  wire [7:0] m_sxy  = sel ? {b_sx, b_sy} : {a_sx, a_sy};
  wire       fin    = sel ? (b_done | b_np) : (a_done | a_np);

  // Maze memory: walls are loaded by the stimulus, visited bits by the DUT
  always @(posedge clk) begin
    if (rst) visited <= '0;
    else begin
      if (m_rd) mem_rdata <= wall[m_addr] | visited[m_addr];
      if (m_wr) visited[m_addr] <= 1'b1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 0; push_cnt <= 0; pop_cnt <= 0;
      s_fail <= 1'b0; s_x <= '0; s_y <= '0;
    end else begin
      if (m_push) begin
        stk_mem[sp]        <= m_sxy;
        push_log[push_cnt] <= m_sxy;
        sp                 <= sp + 1;
        push_cnt           <= push_cnt + 1;
      end
      if (m_pop) begin
        pop_cnt <= pop_cnt + 1;
        if (sp == 0) s_fail <= 1'b1;
        else begin
          s_fail     <= 1'b0;
          {s_x, s_y} <= stk_mem[sp-1];
          sp         <= sp - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input bit inject, output int c);
    c = 0;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    do begin
      @(posedge clk);
      c++;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      if (inject && (c % 25 == 0) && !fin) start_a = 1'b1;
    end while (!fin && c < 2000);
    start_a = 1'b0;
    check("finish_in_budget", 32'(fin), 32'd1);
  endtask

  // Open maze: 30 moves, plus one skipped off-grid +x probe at each (15,y), y=0..14
  localparam int OPEN_CYC = 2 + 30 * 3 + 15;

  initial begin
    int w;
    do_reset();
    check("reset_outputs", 32'({a_addr, a_rd, a_wr, a_push, a_pop, a_sx, a_sy,
                               a_cx, a_cy, a_busy, a_done, a_np}), 32'd0);

    run(1'b0, cyc);
    check("open_cycles", cyc, OPEN_CYC);
    check("open_pushes", push_cnt, 30);
    check("open_pops", pop_cnt, 0);
    check("open_done", 32'({a_done, a_np}), 32'b10);
    check("open_cur", 32'({a_cx, a_cy}), 32'hFF);
    check("open_push15", 32'(push_log[15]), 32'hF0);
    check("open_push29", 32'(push_log[29]), 32'hFE);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    check("done_to_idle", 32'({a_done, a_np, a_busy}), 32'd0);

    do_reset();
    run(1'b1, cyc);
    check("busy_start_cycles", cyc, OPEN_CYC);
    check("busy_start_pushes", push_cnt, 30);
    check("busy_start_cur", 32'({a_cx, a_cy, a_done}), 32'h1FF);

    do_reset();
    wall = '0; wall[8'h30] = 1'b1; wall[8'h21] = 1'b1;
    run(1'b0, cyc);
    check("dead_pops", pop_cnt, 1);
    check("dead_push2", 32'(push_log[2]), 32'h10);
    check("dead_push3", 32'(push_log[3]), 32'h11);
    check("dead_done", 32'({a_done, a_np}), 32'b10);

    do_reset();
    wall = '0; wall[8'h10] = 1'b1; wall[8'h01] = 1'b1;
    run(1'b0, cyc);
    check("encl_pops", pop_cnt, 1);
    check("encl_pushes", push_cnt, 0);
    check("encl_fail", 32'(s_fail), 32'd1);
    check("encl_flags", 32'({a_done, a_np}), 32'b01);
    check("encl_cur", 32'({a_cx, a_cy}), 32'h00);

    wall = '0;
    do_reset();
    sel = 1'b1;
    run(1'b0, cyc);
    check("ovf_pushes", push_cnt, 4);
    check("ovf_push3", 32'(push_log[3]), 32'h30);
    check("ovf_flags", 32'({b_done, b_np}), 32'b01);
    check("ovf_cur", 32'({b_cx, b_cy}), 32'h40);
    sel = 1'b0;

    do_reset();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    w = 0;
    while (!a_push && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("move_seen", 32'(a_push), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_move", 32'({a_addr, a_rd, a_wr, a_push, a_pop, a_sx, a_sy,
                              a_cx, a_cy, a_busy, a_done, a_np}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, cyc);
    check("rerun_cycles", cyc, OPEN_CYC);
    check("rerun_pushes", push_cnt, 30);
    check("rerun_done", 32'({a_done, a_np, a_cx, a_cy}), 32'h2FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
